// File: rtl/nios_system_rx_packet_writer_pkg.sv
// Shared definitions for the RX packet writer: ring geometry, header layout,
// FSM state encoding and small pointer/header helpers.
package nios_system_rx_packet_writer_pkg;

    localparam int BASE_WORD     = 65536;
    localparam int DEPTH_WORDS   = 8192;
    localparam int MAX_PKT_BYTES = 1520;
    localparam int MAX_PKT_WORDS = (MAX_PKT_BYTES + 3) / 4;

    localparam int ADDR_W = 17;
    localparam int PTR_W  = 13;
    localparam int LEN_W  = 16;

    // Header word layout
    localparam int HDR_VALID   = 31;
    localparam int HDR_TRUNC   = 30;
    localparam int HDR_LEN_MSB = 15;
    localparam int HDR_LEN_LSB = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_DROP,
        S_FLUSH,
        S_HDR
    } state_t;

    // Ring offset increment with wrap at DEPTH_WORDS-1.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH_WORDS - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [ADDR_W-1:0] ring_addr(input logic [PTR_W-1:0] off);
        return ADDR_W'(BASE_WORD) + {{(ADDR_W-PTR_W){1'b0}}, off};
    endfunction

    function automatic logic [31:0] make_hdr(input logic trunc, input logic [LEN_W-1:0] len);
        logic [31:0] h;
        h = '0;
        h[HDR_VALID] = 1'b1;
        h[HDR_TRUNC] = trunc;
        h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
        return h;
    endfunction

endpackage

// File: rtl/nios_system_rx_byte_packer.sv
// Little-endian byte-to-word packer.
//   take    : a byte is absorbed this cycle
//   emit    : the current contents (including a byte taken this cycle) leave
//             the packer; lanes reset to 0 and the assembly register clears
//   lanes   : number of filled lanes (0..3)
//   word/be : current contents merged with the incoming byte, plus the
//             byteenable covering exactly the filled lanes
module nios_system_rx_byte_packer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        take,
    input  logic        emit,
    input  logic [7:0]  byte_in,
    output logic [1:0]  lanes,
    output logic [31:0] word,
    output logic [3:0]  be
);

    logic [31:0] asm_q;
    logic [1:0]  lanes_q;
    logic [2:0]  n;

    always_comb begin
        word = asm_q;
        if (take) begin
            case (lanes_q)
                2'd0:    word[7:0]   = byte_in;
                2'd1:    word[15:8]  = byte_in;
                2'd2:    word[23:16] = byte_in;
                default: word[31:24] = byte_in;
            endcase
        end
        n = {1'b0, lanes_q} + {2'b00, take};
        case (n)
            3'd1:    be = 4'b0001;
            3'd2:    be = 4'b0011;
            3'd3:    be = 4'b0111;
            3'd4:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Unused lanes stay zero so partial words are written with clean padding.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            asm_q   <= '0;
            lanes_q <= '0;
        end else if (emit) begin
            asm_q   <= '0;
            lanes_q <= '0;
        end else if (take) begin
            asm_q   <= word;
            lanes_q <= n[1:0];
        end
    end

    assign lanes = lanes_q;

endmodule

// File: rtl/nios_system_rx_packet_writer.sv
// RX packet writer: packs a byte stream into 32-bit words and writes each
// packet into a ring in main memory, data first and header last.
//   s_*      : byte stream in (valid/ready, sop/eop)
//   avm_*    : Avalon-MM write master (registered outputs)
//   rd_ptr   : software consumption pointer; wr_ptr : next free offset
//   pkt_done : one-cycle pulse with pkt_hdr_addr per stored packet
//   drop_count : saturating count of packets refused for lack of space
module nios_system_rx_packet_writer
    import nios_system_rx_packet_writer_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    input  logic              s_sop,
    input  logic              s_eop,
    output logic              s_ready,
    output logic [ADDR_W-1:0] avm_address,
    output logic [3:0]        avm_byteenable,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [PTR_W-1:0]  rd_ptr,
    output logic [PTR_W-1:0]  wr_ptr,
    output logic              pkt_done,
    output logic [ADDR_W-1:0] pkt_hdr_addr,
    output logic [15:0]       drop_count
);

    localparam logic [PTR_W:0]   DEPTH_L = (PTR_W+1)'(DEPTH_WORDS);
    localparam logic [PTR_W:0]   NEED_L  = (PTR_W+1)'(MAX_PKT_WORDS + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PKT_BYTES);

    state_t state, nxt;
    logic [PTR_W-1:0] hdr_q, dptr_q, dptr_cur;
    logic [LEN_W-1:0] cnt_q;
    logic             trunc_q;

    logic [PTR_W:0] used, free_w;
    logic wbusy, retire, acc, room;
    logic take, emit, start, load_data, load_hdr, set_trunc, drop_inc, done;
    logic [1:0]  lanes;
    logic [31:0] pk_word;
    logic [3:0]  pk_be;

    nios_system_rx_byte_packer u_packer (
        .clk     (clk),
        .reset_n (reset_n),
        .take    (take),
        .emit    (emit),
        .byte_in (s_data),
        .lanes   (lanes),
        .word    (pk_word),
        .be      (pk_be)
    );

    always_comb begin
        wbusy  = avm_write && avm_waitrequest;
        retire = avm_write && !avm_waitrequest;
        used   = (wr_ptr >= rd_ptr) ? ({1'b0, wr_ptr} - {1'b0, rd_ptr})
                                    : ({1'b0, wr_ptr} + DEPTH_L - {1'b0, rd_ptr});
        free_w = DEPTH_L - (PTR_W+1)'(1) - used;
        room   = (free_w >= NEED_L);
        // A 4th byte needs the write register; stall only when it is stuck.
        s_ready = !(state == S_FLUSH || state == S_HDR) && !(lanes == 2'd3 && wbusy);
        acc     = s_valid && s_ready;
        // In IDLE the first data word goes right after the header slot.
        dptr_cur = (state == S_IDLE) ? ptr_inc(wr_ptr) : dptr_q;

        nxt = state;
        take = 1'b0; emit = 1'b0; start = 1'b0;
        load_data = 1'b0; load_hdr = 1'b0;
        set_trunc = 1'b0; drop_inc = 1'b0; done = 1'b0;

        case (state)
            S_IDLE: begin
                if (acc && s_sop) begin
                    if (room) begin
                        take  = 1'b1;
                        start = 1'b1;
                        if (s_eop) begin
                            emit = 1'b1; load_data = 1'b1; nxt = S_FLUSH;
                        end else begin
                            nxt = S_COLLECT;
                        end
                    end else begin
                        drop_inc = 1'b1;
                        nxt = s_eop ? S_IDLE : S_DROP;
                    end
                end
            end
            S_COLLECT: begin
                if (acc) begin
                    if (cnt_q < MAX_LEN) begin
                        take = 1'b1;
                        // Full word always goes out; a partial eop word goes
                        // out now only if the write register is free, else
                        // FLUSH picks it up.
                        if (lanes == 2'd3 || (s_eop && !wbusy)) begin
                            emit = 1'b1; load_data = 1'b1;
                        end
                    end else begin
                        set_trunc = 1'b1;
                    end
                    if (s_eop) nxt = S_FLUSH;
                end
            end
            S_DROP: begin
                if (acc && s_eop) nxt = S_IDLE;
            end
            S_FLUSH: begin
                if (!wbusy) begin
                    if (lanes != 2'd0) begin
                        emit = 1'b1; load_data = 1'b1;
                    end else begin
                        load_hdr = 1'b1; nxt = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (retire) begin
                    done = 1'b1; nxt = S_IDLE;
                end
            end
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= S_IDLE;
            hdr_q          <= '0;
            dptr_q         <= '0;
            cnt_q          <= '0;
            trunc_q        <= 1'b0;
            wr_ptr         <= '0;
            avm_write      <= 1'b0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
            pkt_done       <= 1'b0;
            pkt_hdr_addr   <= '0;
            drop_count     <= '0;
        end else begin
            state    <= nxt;
            pkt_done <= done;
            if (start) begin
                hdr_q   <= wr_ptr;
                trunc_q <= 1'b0;
            end
            if (set_trunc) trunc_q <= 1'b1;
            if (start)     cnt_q <= LEN_W'(1);
            else if (take) cnt_q <= cnt_q + 1'b1;

            if (load_data)  dptr_q <= ptr_inc(dptr_cur);
            else if (start) dptr_q <= dptr_cur;

            if (load_data) begin
                avm_write      <= 1'b1;
                avm_address    <= ring_addr(dptr_cur);
                avm_byteenable <= pk_be;
                avm_writedata  <= pk_word;
            end else if (load_hdr) begin
                avm_write      <= 1'b1;
                avm_address    <= ring_addr(hdr_q);
                avm_byteenable <= 4'b1111;
                avm_writedata  <= make_hdr(trunc_q, cnt_q);
            end else if (retire) begin
                avm_write <= 1'b0;
            end

            if (done) begin
                wr_ptr       <= dptr_q;
                pkt_hdr_addr <= ring_addr(hdr_q);
            end
            if (drop_inc && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
        end
    end

    assign avm_chipselect = avm_write;

endmodule
